// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared FSM state and owner encodings for the SRAM arbiter
package mem_arbiter_pkg;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;
  typedef enum logic {
    INST = 1'b0,
    DATA = 1'b1
  } owner_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port SRAM arbiter between fetch and load/store, data has priority
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        flush,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_valid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_valid,
  output logic [31:0] data_rdata,
  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata,
  output logic [1:0]  stallreq
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LAT - 1);

  state_t           state, state_nx;
  owner_t           owner;
  logic [CNT_W-1:0] cnt;
  logic             cancel;
  logic             is_load;
  logic             issue;
  logic             done;

  // reset gates the issue so no access leaks out while resetn is low
  assign issue = resetn && state == IDLE && (inst_req || data_req);
  assign done  = state == WAIT && cnt == '0;

  assign sram_en    = issue;
  assign sram_wen   = (issue && data_req) ? data_wen : 4'b0000;
  assign sram_addr  = data_req ? data_addr : inst_addr;
  assign sram_wdata = data_req ? data_wdata : 32'h0;

  // a flush in the same cycle suppresses the fetch strobe even before cancel is set
  assign inst_valid = resetn && state == RESP && owner == INST && !cancel && !flush;
  assign data_valid = resetn && state == RESP && owner == DATA;
  assign stallreq   = {data_req & ~data_valid, inst_req & ~inst_valid};

  // next-state: issue -> WAIT, counter expiry -> RESP, one response cycle -> IDLE
  always_comb begin
    state_nx = state;
    state_nx = issue ? WAIT : done ? RESP : (state == RESP) ? IDLE : state;
  end

  // state register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else state <= state_nx;
  end

  // access bookkeeping, flush cancel tracking and response data capture
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt        <= '0;
      owner      <= INST;
      cancel     <= 1'b0;
      is_load    <= 1'b0;
      inst_rdata <= 32'h0;
      data_rdata <= 32'h0;
    end else begin
      if (issue) begin
        owner   <= data_req ? DATA : INST;
        is_load <= data_req ? (data_wen == 4'b0000) : 1'b1;
        cnt     <= CNT_INIT;
      end else if (state == WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (issue || state == RESP) cancel <= 1'b0;
      else if (state == WAIT && owner == INST && flush) cancel <= 1'b1;
      if (done && owner == INST && !cancel && !flush) inst_rdata <= sram_rdata;
      if (done && owner == DATA && is_load) data_rdata <= sram_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic against a transaction-timing model
module tb_mem_arbiter;
  localparam int LAT = 3;

  logic        clk, resetn, flush;
  logic        inst_req, inst_valid;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_valid;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [1:0]  stallreq;

  mem_arbiter #(.LAT(LAT)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_valid(inst_valid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_valid(data_valid), .data_rdata(data_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .stallreq(stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  bit          m_busy, m_data, m_load, m_cancel;
  int          m_issue, cyc;
  logic [31:0] m_ird, m_drd;
  bit          saw_iv, saw_dv, saw_fl;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // one clock: compare outputs against the model, then advance the model across the edge
  task automatic step();
    bit en, resp, iv, dv;
    @(negedge clk);
    en   = resetn && !m_busy && (inst_req || data_req);
    resp = m_busy && cyc == m_issue + LAT + 1;
    iv   = resetn && resp && !m_data && !m_cancel && !flush;
    dv   = resetn && resp && m_data;
    check("sram_en", 32'(sram_en), 32'(en));
    check("sram_wen", 32'(sram_wen), (en && data_req) ? 32'(data_wen) : 32'h0);
    if (en) begin
      check("sram_addr", sram_addr, data_req ? data_addr : inst_addr);
      check("sram_wdata", sram_wdata, data_req ? data_wdata : 32'h0);
    end
    check("inst_valid", 32'(inst_valid), 32'(iv));
    check("data_valid", 32'(data_valid), 32'(dv));
    check("inst_rdata", inst_rdata, m_ird);
    check("data_rdata", data_rdata, m_drd);
    check("stallreq", 32'(stallreq), 32'({data_req & !dv, inst_req & !iv}));
    saw_iv = inst_valid;
    saw_dv = data_valid;
    saw_fl = flush;
    if (!resetn) begin
      m_busy = 0; m_cancel = 0; m_ird = 0; m_drd = 0;
    end else if (en) begin
      m_busy = 1; m_issue = cyc; m_data = data_req; m_load = (data_wen == 4'b0000); m_cancel = 0;
    end else if (m_busy) begin
      if (cyc == m_issue + LAT) begin
        if (m_data && m_load) m_drd = sram_rdata;
        if (!m_data && !m_cancel && !flush) m_ird = sram_rdata;
      end
      if (flush && !m_data && cyc <= m_issue + LAT) m_cancel = 1;
      if (cyc == m_issue + LAT + 1) m_busy = 0;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // requester behaviour: drop on response (or flush for fetch), optionally raise new random requests
  task automatic follow(input bit rnd);
    if (saw_iv || saw_fl) inst_req = 0;
    if (saw_dv) data_req = 0;
    sram_rdata = $urandom;
    flush = 0;
    if (rnd) begin
      if (!inst_req && $urandom % 3 == 0) begin
        inst_req = 1; inst_addr = $urandom;
      end
      if (!data_req && $urandom % 3 == 0) begin
        data_req = 1; data_addr = $urandom; data_wdata = $urandom;
        data_wen = ($urandom % 2 == 0) ? 4'b0000 : 4'($urandom);
      end
      flush  = ($urandom % 8 == 0);
      resetn = ($urandom % 150 != 0);
    end
  endtask

  initial begin
    resetn = 0; flush = 0; inst_req = 0; inst_addr = 0; data_req = 0; data_wen = 0;
    data_addr = 0; data_wdata = 0; sram_rdata = 0;
    m_busy = 0; m_data = 0; m_load = 0; m_cancel = 0; m_issue = 0; cyc = 0;
    m_ird = 0; m_drd = 0; saw_iv = 0; saw_dv = 0; saw_fl = 0;
    @(posedge clk);
    #1;
    inst_req = 1; data_req = 1;
    step(); step();
    resetn = 1; inst_req = 0; data_req = 0;
    step(); follow(0);
    inst_req = 1; inst_addr = 32'hBFC00000;
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h80000010; data_wdata = 0;
    repeat (12) begin step(); follow(0); end
    data_req = 1; data_wen = 4'b0011; data_addr = 32'h80000020; data_wdata = 32'h0000BEEF;
    step(); follow(0);
    flush = 1;
    repeat (6) begin step(); follow(0); end
    inst_req = 1; inst_addr = 32'hBFC00004;
    step(); follow(0);
    flush = 1;
    repeat (6) begin step(); follow(0); end
    inst_req = 1; inst_addr = 32'hBFC00008;
    repeat (7) begin step(); follow(0); end
    inst_req = 1; inst_addr = 32'hBFC0000C;
    step(); follow(0);
    step(); follow(0);
    resetn = 0;
    step(); follow(0);
    resetn = 1;
    repeat (8) begin step(); follow(0); end
    repeat (4000) begin step(); follow(1); end
    resetn = 1;
    repeat (10) begin step(); follow(0); end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
